// File: rtl/vram_responder.sv
// rtl/vram_responder.sv - chroni video-read responder with CPU port arbitration onto one VRAM
module vram_responder #(
  parameter int RAM_AW        = 16,
  parameter int RAM_LATENCY   = 1,
  parameter int MAX_VID_BURST = 4
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [12:0]       vid_addr,
  input  logic [7:0]        vid_addr_page,
  input  logic              vid_rd_req,
  output logic              vid_rd_ack,
  output logic [7:0]        vid_data,
  input  logic [20:0]       cpu_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int SW = $clog2(MAX_VID_BURST + 1);
  localparam int LW = $clog2(RAM_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    VID_WAIT,
    VID_ACK,
    CPU_RD_WAIT,
    CPU_RD_ACK,
    CPU_WR_ACK
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   wait_cnt, wait_nxt;
  logic [SW-1:0]   starv_cnt, starv_nxt;

  logic              vid_rd_ack_nxt, cpu_ack_nxt;
  logic [7:0]        vid_data_nxt, cpu_rdata_nxt;
  logic              ram_en_nxt, ram_we_nxt;
  logic [RAM_AW-1:0] ram_addr_nxt;
  logic [7:0]        ram_wdata_nxt;

  logic [20:0] vid_full;
  logic        cpu_wins;
  logic        wait_done;

  // {page, offset} wraps onto the RAM; bits above RAM_AW are deliberately dropped
  assign vid_full  = {vid_addr_page, vid_addr};
  assign cpu_wins  = cpu_req && (!vid_rd_req || (starv_cnt == SW'(MAX_VID_BURST)));
  assign wait_done = (wait_cnt == LW'(RAM_LATENCY));

  logic unused_hi_bits;
  assign unused_hi_bits = ^{vid_full[20:RAM_AW], cpu_addr[20:RAM_AW]};

  // Next-state, arbitration and registered-output values; requests are only looked at in IDLE
  always_comb begin
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    starv_nxt      = starv_cnt;
    vid_rd_ack_nxt = 1'b0;
    cpu_ack_nxt    = 1'b0;
    vid_data_nxt   = vid_data;
    cpu_rdata_nxt  = cpu_rdata;
    ram_en_nxt     = 1'b0;
    ram_we_nxt     = 1'b0;
    ram_addr_nxt   = ram_addr;
    ram_wdata_nxt  = ram_wdata;

    case (state)
      IDLE: begin
        if (cpu_wins) begin
          starv_nxt    = '0;
          ram_en_nxt   = 1'b1;
          ram_addr_nxt = cpu_addr[RAM_AW-1:0];
          wait_nxt     = '0;
          if (cpu_we) begin
            // Writes finish in the strobe cycle itself, so the ack rides along with it
            ram_we_nxt    = 1'b1;
            ram_wdata_nxt = cpu_wdata;
            cpu_ack_nxt   = 1'b1;
            state_nxt     = CPU_WR_ACK;
          end else begin
            state_nxt = CPU_RD_WAIT;
          end
        end else if (vid_rd_req) begin
          ram_en_nxt   = 1'b1;
          ram_addr_nxt = vid_full[RAM_AW-1:0];
          wait_nxt     = '0;
          state_nxt    = VID_WAIT;
          if (cpu_req) begin
            if (starv_cnt != SW'(MAX_VID_BURST))
              starv_nxt = starv_cnt + SW'(1);
          end else begin
            starv_nxt = '0;
          end
        end else begin
          starv_nxt = '0;
        end
      end

      VID_WAIT: begin
        if (wait_done) begin
          vid_data_nxt   = ram_rdata;
          vid_rd_ack_nxt = 1'b1;
          state_nxt      = VID_ACK;
        end else begin
          wait_nxt = wait_cnt + LW'(1);
        end
      end

      CPU_RD_WAIT: begin
        if (wait_done) begin
          cpu_rdata_nxt = ram_rdata;
          cpu_ack_nxt   = 1'b1;
          state_nxt     = CPU_RD_ACK;
        end else begin
          wait_nxt = wait_cnt + LW'(1);
        end
      end

      // Ack cycles never sample: chroni moves its address on the ack edge
      VID_ACK, CPU_RD_ACK, CPU_WR_ACK: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and all outputs are registered; reset abandons any transaction in flight
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starv_cnt  <= '0;
      vid_rd_ack <= 1'b0;
      vid_data   <= 8'h00;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= 8'h00;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 8'h00;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      starv_cnt  <= starv_nxt;
      vid_rd_ack <= vid_rd_ack_nxt;
      vid_data   <= vid_data_nxt;
      cpu_ack    <= cpu_ack_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      ram_en     <= ram_en_nxt;
      ram_we     <= ram_we_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_wdata  <= ram_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_vram_responder.sv
// tb/tb_vram_responder.sv - directed self-checking bench for vram_responder
module tb_vram_responder;

  logic        vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Instance with RAM_LATENCY = 1
  logic        reset;
  logic [12:0] vid_addr;
  logic [7:0]  vid_addr_page;
  logic        vid_rd_req;
  logic        vid_rd_ack;
  logic [7:0]  vid_data;
  logic [20:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  // Instance with RAM_LATENCY = 2 (video only)
  logic        reset2;
  logic [12:0] vid_addr2;
  logic [7:0]  vid_addr_page2;
  logic        vid_rd_req2;
  logic        vid_rd_ack2;
  logic [7:0]  vid_data2;
  logic [20:0] cpu_addr2;
  logic        cpu_req2;
  logic        cpu_we2;
  logic [7:0]  cpu_wdata2;
  logic [7:0]  cpu_rdata2;
  logic        cpu_ack2;
  logic        ram_en2;
  logic        ram_we2;
  logic [15:0] ram_addr2;
  logic [7:0]  ram_wdata2;
  logic [7:0]  ram_rdata2;

  int passed = 0;
  int total  = 0;

  vram_responder #(.RAM_AW(16), .RAM_LATENCY(1), .MAX_VID_BURST(4)) dut (
    .vga_clk(vga_clk), .reset(reset),
    .vid_addr(vid_addr), .vid_addr_page(vid_addr_page), .vid_rd_req(vid_rd_req),
    .vid_rd_ack(vid_rd_ack), .vid_data(vid_data),
    .cpu_addr(cpu_addr), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  vram_responder #(.RAM_AW(16), .RAM_LATENCY(2), .MAX_VID_BURST(4)) dut2 (
    .vga_clk(vga_clk), .reset(reset2),
    .vid_addr(vid_addr2), .vid_addr_page(vid_addr_page2), .vid_rd_req(vid_rd_req2),
    .vid_rd_ack(vid_rd_ack2), .vid_data(vid_data2),
    .cpu_addr(cpu_addr2), .cpu_req(cpu_req2), .cpu_we(cpu_we2), .cpu_wdata(cpu_wdata2),
    .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2),
    .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_rdata(ram_rdata2)
  );

  // VRAM model: untouched words read as addr[7:0]^addr[15:8], 0x0401/0x8401 preloaded with 0x41
  logic [7:0] wr_mem   [0:65535];
  bit         wr_valid [0:65535];
  logic [7:0] rd1_q;
  logic [7:0] rd2a_q;
  logic [7:0] rd2b_q;

  function automatic logic [7:0] ram_word(input logic [15:0] a);
    if (wr_valid[a]) return wr_mem[a];
    if (a == 16'h8401 || a == 16'h0401) return 8'h41;
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge vga_clk) begin
    if (ram_en && ram_we) begin
      wr_mem[ram_addr]   <= ram_wdata;
      wr_valid[ram_addr] <= 1'b1;
    end
    rd1_q  <= (ram_en && !ram_we) ? ram_word(ram_addr) : 8'hEE;
    rd2a_q <= (ram_en2 && !ram_we2) ? ram_word(ram_addr2) : 8'hEE;
    rd2b_q <= rd2a_q;
  end

  assign ram_rdata  = rd1_q;
  assign ram_rdata2 = rd2b_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the edge; invariants checked every cycle
  task automatic tick();
    @(posedge vga_clk);
    #1;
    check("ack_exclusive", 32'(vid_rd_ack & cpu_ack), 32'd0);
    check("we_without_en", 32'(ram_we & ~ram_en), 32'd0);
    check("we_without_en2", 32'(ram_we2 & ~ram_en2), 32'd0);
  endtask

  // Called in an IDLE cycle; returns in the following IDLE cycle with vid_rd_req still high
  task automatic vid_read(input logic [7:0] pg, input logic [12:0] off,
                          input logic [15:0] exp_addr, input logic [7:0] exp_data);
    vid_addr_page = pg;
    vid_addr      = off;
    vid_rd_req    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("vid_ram_en", 32'(ram_en), 32'(k == 1));
      check("vid_ack_timing", 32'(vid_rd_ack), 32'(k == 3));
      if (k == 1) begin
        check("vid_ram_addr", 32'(ram_addr), 32'(exp_addr));
        check("vid_ram_we", 32'(ram_we), 32'd0);
      end
      if (k == 3) check("vid_data", 32'(vid_data), 32'(exp_data));
    end
    tick();
    check("vid_ack_one_cycle", 32'(vid_rd_ack), 32'd0);
  endtask

  // Step until either ack appears; 'T' on timeout, which fails the caller's comparison
  task automatic wait_ack(output logic [7:0] kind);
    kind = "T";
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vid_rd_ack) begin kind = "V"; break; end
      if (cpu_ack)    begin kind = "C"; break; end
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, 32'({vid_rd_ack, vid_data, cpu_ack, cpu_rdata, ram_en, ram_we}), 32'd0);
    check(tag, 32'({ram_addr, ram_wdata}), 32'd0);
  endtask

  logic [7:0]  kind;
  string       seq;
  logic [12:0] b2b_off  [0:7];
  logic [7:0]  b2b_data [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; vid_addr = '0; vid_addr_page = '0; vid_rd_req = 1'b0;
    cpu_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    reset2 = 1'b1; vid_addr2 = '0; vid_addr_page2 = '0; vid_rd_req2 = 1'b0;
    cpu_addr2 = '0; cpu_req2 = 1'b0; cpu_we2 = 1'b0; cpu_wdata2 = '0;

    // page 0x04 -> ram addr 0x84xx; data = 0x84 ^ low byte
    b2b_off[0] = 13'h0402; b2b_data[0] = 8'h86;
    b2b_off[1] = 13'h0403; b2b_data[1] = 8'h87;
    b2b_off[2] = 13'h0404; b2b_data[2] = 8'h80;
    b2b_off[3] = 13'h0405; b2b_data[3] = 8'h81;
    b2b_off[4] = 13'h0406; b2b_data[4] = 8'h82;
    b2b_off[5] = 13'h0407; b2b_data[5] = 8'h83;
    b2b_off[6] = 13'h0408; b2b_data[6] = 8'h8C;
    b2b_off[7] = 13'h0409; b2b_data[7] = 8'h8D;

    // Reset, then idle
    tick(); tick();
    check_outs_zero("reset_outs");
    reset = 1'b0;
    tick();
    check_outs_zero("idle_outs");

    // First video read: {0x04,0x0401} = 0x08401 -> 0x8401
    vid_read(8'h04, 13'h0401, 16'h8401, 8'h41);

    // Eight back-to-back reads with rd_req held; one ack every 4 cycles
    for (int i = 0; i < 8; i++) vid_read(8'h04, b2b_off[i], {8'h84, 3'b000, b2b_off[i][4:0]} , b2b_data[i]);

    // Truncation: {0xFF,0x1F34} = 0x1FFF34 -> 0xFF34, data 0x34^0xFF
    vid_read(8'hFF, 13'h1F34, 16'hFF34, 8'hCB);
    vid_rd_req = 1'b0;
    tick();

    // Request dropped after grant still completes: {0x08,0x0401} = 0x10401 -> 0x0401
    vid_addr_page = 8'h08; vid_addr = 13'h0401; vid_rd_req = 1'b1;
    tick();
    vid_rd_req = 1'b0;
    check("drop_ram_en", 32'(ram_en), 32'd1);
    check("drop_ram_addr", 32'(ram_addr), 32'h0401);
    tick();
    check("drop_no_early_ack", 32'(vid_rd_ack), 32'd0);
    tick();
    check("drop_ack", 32'(vid_rd_ack), 32'd1);
    check("drop_data", 32'(vid_data), 32'h41);
    tick();

    // CPU write 0x5A to 0x00123
    cpu_addr = 21'h00123; cpu_we = 1'b1; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    check("wr_strobe", 32'({ram_en, ram_we, cpu_ack}), 32'h7);
    check("wr_addr", 32'(ram_addr), 32'h0123);
    check("wr_wdata", 32'(ram_wdata), 32'h5A);
    tick();
    check("wr_done", 32'({ram_en, ram_we, cpu_ack}), 32'h0);
    check("wr_keeps_rdata", 32'(cpu_rdata), 32'h00);

    // CPU read back
    cpu_we = 1'b0; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    check("rd_strobe", 32'({ram_en, ram_we}), 32'h2);
    check("rd_addr", 32'(ram_addr), 32'h0123);
    tick();
    check("rd_no_early_ack", 32'(cpu_ack), 32'd0);
    tick();
    check("rd_ack", 32'(cpu_ack), 32'd1);
    check("rd_data", 32'(cpu_rdata), 32'h5A);
    tick();
    check("rd_ack_one_cycle", 32'(cpu_ack), 32'd0);

    // Contention: video 0x0010 (data 0x10), CPU read 0x1A0BC -> 0xA0BC (data 0x1C)
    vid_addr_page = 8'h00; vid_addr = 13'h0010;
    cpu_addr = 21'h1A0BC; cpu_we = 1'b0;
    vid_rd_req = 1'b1; cpu_req = 1'b1;
    seq = "VVVVCVVVVC";
    for (int i = 0; i < 10; i++) begin
      wait_ack(kind);
      check("grant_order", 32'(kind), 32'(seq[i]));
      if (kind == "V") check("cont_vid_data", 32'(vid_data), 32'h10);
      if (kind == "C") check("cont_cpu_data", 32'(cpu_rdata), 32'h1C);
    end
    vid_rd_req = 1'b0; cpu_req = 1'b0;
    tick();

    // cpu_req dropped before its slot clears the starvation count
    vid_rd_req = 1'b1; cpu_req = 1'b1;
    wait_ack(kind); check("pre_drop_0", 32'(kind), 32'("V"));
    wait_ack(kind); check("pre_drop_1", 32'(kind), 32'("V"));
    cpu_req = 1'b0;
    wait_ack(kind); check("during_drop", 32'(kind), 32'("V"));
    cpu_req = 1'b1;
    seq = "VVVVC";
    for (int i = 0; i < 5; i++) begin
      wait_ack(kind);
      check("post_drop_order", 32'(kind), 32'(seq[i]));
    end
    vid_rd_req = 1'b0; cpu_req = 1'b0;
    tick();

    // Reset while in VID_WAIT abandons the read
    vid_addr_page = 8'h00; vid_addr = 13'h0010; vid_rd_req = 1'b1;
    tick();
    check("rst_mid_ram_en", 32'(ram_en), 32'd1);
    reset = 1'b1; vid_rd_req = 1'b0;
    tick();
    check_outs_zero("rst_mid_outs");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_ack", 32'({vid_rd_ack, cpu_ack, ram_en}), 32'd0);
    end
    vid_read(8'h00, 13'h0010, 16'h0010, 8'h10);
    vid_rd_req = 1'b0;
    tick();

    // RAM_LATENCY = 2: ack at T+4; {0x04,0x0405} -> 0x8405, data 0x81
    reset2 = 1'b0;
    tick();
    check("l2_idle_outs", 32'({vid_rd_ack2, vid_data2, ram_en2, ram_we2}), 32'd0);
    vid_addr_page2 = 8'h04; vid_addr2 = 13'h0405; vid_rd_req2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("l2_ram_en", 32'(ram_en2), 32'(k == 1));
      check("l2_ack_timing", 32'(vid_rd_ack2), 32'(k == 4));
      if (k == 1) check("l2_ram_addr", 32'(ram_addr2), 32'h8405);
      if (k == 4) check("l2_data", 32'(vid_data2), 32'h81);
    end
    tick();
    vid_rd_req2 = 1'b0;
    check("l2_ack_one_cycle", 32'(vid_rd_ack2), 32'd0);
    tick();

    // RAM_LATENCY = 2: reset in the second VID_WAIT cycle, then a normal read
    vid_addr_page2 = 8'h00; vid_addr2 = 13'h0020; vid_rd_req2 = 1'b1;
    tick();
    tick();
    reset2 = 1'b1; vid_rd_req2 = 1'b0;
    tick();
    check("l2_rst_outs", 32'({vid_rd_ack2, vid_data2, ram_en2, ram_we2}), 32'd0);
    check("l2_rst_addr", 32'(ram_addr2), 32'd0);
    reset2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l2_rst_no_ack", 32'({vid_rd_ack2, ram_en2}), 32'd0);
    end
    vid_addr_page2 = 8'h08; vid_addr2 = 13'h0401; vid_rd_req2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) vid_rd_req2 = 1'b0;
      check("l2_post_rst_ram_en", 32'(ram_en2), 32'(k == 1));
      check("l2_post_rst_ack", 32'(vid_rd_ack2), 32'(k == 4));
      if (k == 4) check("l2_post_rst_data", 32'(vid_data2), 32'h41);
    end
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
